// File: rtl/lfsr_checker.sv
// Receive-side verifier for an N-bit LFSR word stream: hunts for a seed, verifies, locks, counts errors.
// Build option LFSR_CHK_WORDCNT_EN adds the locked-word counter; otherwise word_count_o is tied to 0.
module lfsr_checker #(
   parameter int             N           = 8,
   parameter logic [N-1:0]   TAPS        = 8'hB8,
   parameter int             LOCK_COUNT  = 16,
   parameter int             LOSS_THRESH = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid_i,
   input  logic [N-1:0]  in_data_i,
   input  logic          clr_cnt_i,
   output logic          locked_o,
   output logic          err_pulse_o,
   output logic [15:0]   err_count_o,
   output logic [31:0]   word_count_o
);

   localparam logic [1:0] ST_HUNT   = 2'd0;
   localparam logic [1:0] ST_VERIFY = 2'd1;
   localparam logic [1:0] ST_LOCKED = 2'd2;
   localparam logic [7:0] LOCK_C    = 8'(LOCK_COUNT);
   localparam logic [7:0] LOSS_C    = 8'(LOSS_THRESH);

   logic [1:0]    state_q, state_d;
   logic [N-1:0]  exp_q, exp_d;
   logic [7:0]    run_q, run_d;
   logic [7:0]    run_inc_s;
   logic          match_s;
   logic          zero_s;
   logic          err_s;
   logic          locked_q;
   logic          err_pulse_q;
   logic [15:0]   err_count_q, err_count_d;

   function automatic logic [N-1:0] lfsr_next(input logic [N-1:0] s);
      return {s[N-2:0], ^(s & TAPS)};
   endfunction

   assign run_inc_s = run_q + 8'd1;
   assign match_s   = (in_data_i == exp_q);
   assign zero_s    = (in_data_i == {N{1'b0}});

   // Hunt / verify / locked sequencing; nothing moves without a valid word
   always_comb begin
      state_d = state_q;
      exp_d   = exp_q;
      run_d   = run_q;
      err_s   = 1'b0;
      if (in_valid_i) begin
         case (state_q)
            ST_HUNT: begin
               // The all-zero word is the LFSR lock-up state and can never seed.
               if (!zero_s) begin
                  exp_d   = lfsr_next(in_data_i);
                  run_d   = 8'd0;
                  state_d = ST_VERIFY;
               end else begin
                  state_d = ST_HUNT;
               end
            end
            ST_VERIFY: begin
               if (match_s) begin
                  exp_d = lfsr_next(exp_q);
                  if (run_inc_s == LOCK_C) begin
                     run_d   = 8'd0;
                     state_d = ST_LOCKED;
                  end else begin
                     run_d = run_inc_s;
                  end
               end else if (!zero_s) begin
                  exp_d = lfsr_next(in_data_i);
                  run_d = 8'd0;
               end else begin
                  state_d = ST_HUNT;
               end
            end
            ST_LOCKED: begin
               // Flywheel: once locked the local generator never reseeds from the line.
               exp_d = lfsr_next(exp_q);
               if (match_s) begin
                  run_d = 8'd0;
               end else begin
                  err_s = 1'b1;
                  if (run_inc_s == LOSS_C) begin
                     run_d   = 8'd0;
                     state_d = ST_HUNT;
                  end else begin
                     run_d = run_inc_s;
                  end
               end
            end
            default: begin
               state_d = ST_HUNT;
               exp_d   = {N{1'b0}};
               run_d   = 8'd0;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Saturating error counter; a clear coinciding with an error keeps that error
   always_comb begin
      err_count_d = err_count_q;
      if (clr_cnt_i) begin
         err_count_d = err_s ? 16'd1 : 16'd0;
      end else if (err_s && (err_count_q != 16'hFFFF)) begin
         err_count_d = err_count_q + 16'd1;
      end else begin
         err_count_d = err_count_q;
      end
   end

   // Checker state and registered status outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_HUNT;
         exp_q       <= {N{1'b0}};
         run_q       <= 8'd0;
         locked_q    <= 1'b0;
         err_pulse_q <= 1'b0;
         err_count_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         exp_q       <= exp_d;
         run_q       <= run_d;
         locked_q    <= (state_d == ST_LOCKED);
         err_pulse_q <= err_s;
         err_count_q <= err_count_d;
      end
   end

   assign locked_o    = locked_q;
   assign err_pulse_o = err_pulse_q;
   assign err_count_o = err_count_q;

`ifdef LFSR_CHK_WORDCNT_EN
   logic [31:0] word_cnt_q, word_cnt_d;
   logic        word_hit_s;

   assign word_hit_s = in_valid_i && (state_q == ST_LOCKED);

   // Wrapping count of valid words seen while already locked
   always_comb begin
      word_cnt_d = word_cnt_q;
      if (clr_cnt_i) begin
         word_cnt_d = word_hit_s ? 32'd1 : 32'd0;
      end else if (word_hit_s) begin
         word_cnt_d = word_cnt_q + 32'd1;
      end else begin
         word_cnt_d = word_cnt_q;
      end
   end

   // Locked-word counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_cnt_q <= 32'd0;
      end else begin
         word_cnt_q <= word_cnt_d;
      end
   end

   assign word_count_o = word_cnt_q;
`else
   assign word_count_o = 32'd0;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Self-checking bench for lfsr_checker: directed vector table, async-reset and saturation
// sequences, then randomized traffic against a behavioural reference model.
module tb_lfsr_checker;

   localparam logic [7:0] TAPS = 8'hB8;
   localparam int         LC   = 4;
   localparam int         LT   = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        clr_cnt = 1'b0;
   logic        locked, err_pulse;
   logic [15:0] err_count;
   logic [31:0] word_count;

   logic        s_valid = 1'b0;
   logic [7:0]  s_data = 8'h00;
   logic        s_clr = 1'b0;
   logic        s_locked, s_pulse;
   logic [15:0] s_err;
   logic [31:0] s_words;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   lfsr_checker #(.N(8), .TAPS(TAPS), .LOCK_COUNT(LC), .LOSS_THRESH(LT)) dut (
      .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_data_i(in_data), .clr_cnt_i(clr_cnt),
      .locked_o(locked), .err_pulse_o(err_pulse), .err_count_o(err_count), .word_count_o(word_count));

   // Second instance with the widest loss window so saturation is reachable while locked
   lfsr_checker #(.N(8), .TAPS(TAPS), .LOCK_COUNT(1), .LOSS_THRESH(255)) u_sat (
      .clk(clk), .rst(rst), .in_valid_i(s_valid), .in_data_i(s_data), .clr_cnt_i(s_clr),
      .locked_o(s_locked), .err_pulse_o(s_pulse), .err_count_o(s_err), .word_count_o(s_words));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic [7:0] nxt(input logic [7:0] s);
      int fb;
      fb = $countones(s & TAPS) % 2;
      return (8'((int'(s) * 2) % 256)) | 8'(fb);
   endfunction

   task automatic drive(input logic v, input logic [7:0] d, input logic c);
      @(negedge clk);
      in_valid = v; in_data = d; clr_cnt = c;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; clr_cnt = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // ---------------- behavioural reference model ----------------
   typedef enum int {M_HUNT, M_VERIFY, M_LOCKED} mmode_t;
   mmode_t     m_mode;
   logic [7:0] m_expect;
   int         m_streak;
   int         m_errs;
   longint     m_words;
   logic       m_pulse;

   task automatic model_init();
      m_mode = M_HUNT; m_expect = 8'h00; m_streak = 0; m_errs = 0; m_words = 0; m_pulse = 1'b0;
   endtask

   task automatic model_step(input logic v, input logic [7:0] d, input logic c);
      logic counted;
      counted = 1'b0;
      m_pulse = 1'b0;
      if (v) begin
`ifdef LFSR_CHK_WORDCNT_EN
         if (m_mode == M_LOCKED) begin
            counted = 1'b1;
            m_words = (m_words + 1) % 64'h1_0000_0000;
         end
`endif
         if (m_mode == M_HUNT) begin
            if (d != 8'h00) begin
               m_expect = nxt(d); m_streak = 0; m_mode = M_VERIFY;
            end
         end else if (m_mode == M_VERIFY) begin
            if (d == m_expect) begin
               m_expect = nxt(m_expect);
               m_streak++;
               if (m_streak == LC) begin m_mode = M_LOCKED; m_streak = 0; end
            end else if (d != 8'h00) begin
               m_expect = nxt(d); m_streak = 0;
            end else begin
               m_mode = M_HUNT;
            end
         end else begin
            if (d != m_expect) begin
               m_pulse = 1'b1;
               m_errs  = (m_errs < 65535) ? m_errs + 1 : 65535;
               m_streak++;
               if (m_streak == LT) begin m_mode = M_HUNT; m_streak = 0; end
            end else begin
               m_streak = 0;
            end
            m_expect = nxt(m_expect);
         end
      end
      if (c) begin
         m_errs  = m_pulse ? 1 : 0;
         m_words = counted ? 1 : 0;
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic       rst_first;
      logic       v;
      logic [7:0] d;
      logic       c;
      logic       l;
      logic       p;
      logic [15:0] e;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input logic r, input logic v, input logic [7:0] d, input logic c,
                      input logic l, input logic p, input logic [15:0] e);
      vec_t x;
      x.rst_first = r; x.v = v; x.d = d; x.c = c; x.l = l; x.p = p; x.e = e;
      tbl.push_back(x);
   endtask

   initial begin
      logic [7:0] gen;
      int         burst;
      logic       rv, rc;
      logic [7:0] rd;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset_locked", 32'(locked), 32'd0);
      check("reset_pulse", 32'(err_pulse), 32'd0);
      check("reset_errcnt", 32'(err_count), 32'd0);
      check("reset_wordcnt", word_count, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // lock acquisition, flywheel error, hold on idle, clear, loss of lock, re-hunt
      add(1, 1, 8'h01, 0, 0, 0, 16'd0);
      add(0, 1, 8'h02, 0, 0, 0, 16'd0);
      add(0, 1, 8'h04, 0, 0, 0, 16'd0);
      add(0, 1, 8'h08, 0, 0, 0, 16'd0);
      add(0, 1, 8'h11, 0, 1, 0, 16'd0);
      add(0, 1, 8'h23, 0, 1, 0, 16'd0);
      add(0, 1, 8'hFF, 0, 1, 1, 16'd1);
      add(0, 1, 8'h8E, 0, 1, 0, 16'd1);
      add(0, 0, 8'h55, 0, 1, 0, 16'd1);
      add(0, 1, 8'h1C, 0, 1, 0, 16'd1);
      add(0, 0, 8'h00, 1, 1, 0, 16'd0);
      add(0, 1, 8'h00, 0, 1, 1, 16'd1);
      add(0, 1, 8'h00, 0, 1, 1, 16'd2);
      add(0, 1, 8'h00, 0, 1, 1, 16'd3);
      add(0, 1, 8'h00, 0, 0, 1, 16'd4);
      add(0, 1, 8'h00, 0, 0, 0, 16'd4);
      add(0, 1, 8'h01, 0, 0, 0, 16'd4);
      add(0, 1, 8'h02, 0, 0, 0, 16'd4);
      add(0, 1, 8'h04, 0, 0, 0, 16'd4);
      add(0, 1, 8'h08, 0, 0, 0, 16'd4);
      add(0, 1, 8'h11, 0, 1, 0, 16'd4);
      add(0, 1, 8'h99, 1, 1, 1, 16'd1);
      // VERIFY reseed from 0x55
      add(1, 1, 8'h01, 0, 0, 0, 16'd0);
      add(0, 1, 8'h02, 0, 0, 0, 16'd0);
      add(0, 1, 8'h55, 0, 0, 0, 16'd0);
      add(0, 1, 8'hAB, 0, 0, 0, 16'd0);
      add(0, 1, 8'h57, 0, 0, 0, 16'd0);
      add(0, 1, 8'hAF, 0, 0, 0, 16'd0);
      add(0, 1, 8'h5F, 0, 1, 0, 16'd0);
      // zero word in VERIFY drops back to HUNT
      add(1, 1, 8'h01, 0, 0, 0, 16'd0);
      add(0, 1, 8'h00, 0, 0, 0, 16'd0);
      add(0, 1, 8'h02, 0, 0, 0, 16'd0);
      add(0, 1, 8'h04, 0, 0, 0, 16'd0);
      add(0, 1, 8'h08, 0, 0, 0, 16'd0);
      add(0, 1, 8'h11, 0, 0, 0, 16'd0);
      add(0, 1, 8'h23, 0, 1, 0, 16'd0);

      foreach (tbl[i]) begin
         if (tbl[i].rst_first) do_reset();
         drive(tbl[i].v, tbl[i].d, tbl[i].c);
         check($sformatf("vec%0d_locked", i), 32'(locked), 32'(tbl[i].l));
         check($sformatf("vec%0d_pulse", i), 32'(err_pulse), 32'(tbl[i].p));
         check($sformatf("vec%0d_errcnt", i), 32'(err_count), 32'(tbl[i].e));
      end

      // locked word count, then async reset between clock edges
      do_reset();
      gen = 8'h01;
      for (int i = 0; i < 5; i++) begin drive(1'b1, gen, 1'b0); gen = nxt(gen); end
      check("wc_lock", 32'(locked), 32'd1);
      for (int i = 0; i < 10; i++) begin drive(1'b1, gen, 1'b0); gen = nxt(gen); end
`ifdef LFSR_CHK_WORDCNT_EN
      check("wc_ten", word_count, 32'd10);
`else
      check("wc_ten", word_count, 32'd0);
`endif
      drive(1'b1, ~gen, 1'b0);
      check("ar_pre_pulse", 32'(err_pulse), 32'd1);
      check("ar_pre_err", 32'(err_count), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("ar_locked", 32'(locked), 32'd0);
      check("ar_pulse", 32'(err_pulse), 32'd0);
      check("ar_errcnt", 32'(err_count), 32'd0);
      check("ar_wordcnt", word_count, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // saturation on the wide-window instance
      @(negedge clk);
      s_valid = 1'b1; s_data = 8'h01; s_clr = 1'b0;
      @(negedge clk);
      s_data = 8'h02;
      gen = nxt(8'h02);
      for (int g = 0; g < 260; g++) begin
         for (int k = 0; k < 254; k++) begin
            @(negedge clk);
            s_data = ~gen;
            gen = nxt(gen);
         end
         @(negedge clk);
         s_data = gen;
         gen = nxt(gen);
      end
      @(negedge clk);
      s_valid = 1'b0;
      @(posedge clk);
      #1;
      check("sat_locked", 32'(s_locked), 32'd1);
      check("sat_errcnt", 32'(s_err), 32'hFFFF);
      @(negedge clk);
      s_valid = 1'b1; s_data = ~gen; s_clr = 1'b1;
      @(posedge clk);
      #1;
      check("sat_clr_err", 32'(s_err), 32'd1);
      check("sat_clr_pulse", 32'(s_pulse), 32'd1);
      @(negedge clk);
      s_valid = 1'b0; s_clr = 1'b0;

      // randomized traffic against the reference model
      do_reset();
      model_init();
      gen = 8'h5A;
      burst = 0;
      for (int i = 0; i < 3000; i++) begin
         rv = ($urandom % 4) != 0;
         rc = ($urandom % 40) == 0;
         if (burst == 0 && ($urandom % 150) == 0) burst = 5;
         if (burst > 0) begin
            rd = gen ^ 8'h3C;
            if (rv) burst--;
         end else begin
            case ($urandom % 16)
               11: rd = 8'h00;
               12, 13: rd = 8'($urandom);
               default: rd = gen;
            endcase
         end
         if (rv) gen = nxt(gen);
         model_step(rv, rd, rc);
         drive(rv, rd, rc);
         check("rnd_locked", 32'(locked), 32'(m_mode == M_LOCKED));
         check("rnd_pulse", 32'(err_pulse), 32'(m_pulse));
         check("rnd_errcnt", 32'(err_count), 32'(m_errs));
         check("rnd_wordcnt", word_count, 32'(m_words));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Receive-side verifier for the 8-bit LFSR pseudo-random stream produced by the PRNG generator. It self-synchronises to an incoming word stream, regenerates the expected sequence locally, and declares lock after a run of consecutive matches. Once locked, it counts word errors and declares loss of lock after a run of consecutive mismatches. It sits at the far end of a link or loopback path to qualify the generator and the path, and reports status to LEDs or a debug register.

## Interface
- N, 8, word and LFSR width.
- TAPS, 8'hB8, feedback mask selecting bits 7, 5, 4 and 3 (x^8+x^6+x^5+x^4+1).
- LOCK_COUNT, 16, consecutive matches required to declare lock; range 1..255.
- LOSS_THRESH, 4, consecutive mismatches while locked that force re-hunt; range 1..255.

- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  in_data is sampled on this cycle.
- in_data  input  N  received LFSR word.
- clr_cnt  input  1  synchronous clear of err_count.
- locked  output  1  high while in LOCKED.
- err_pulse  output  1  one-cycle strobe on each mismatch counted in LOCKED.
- err_count  output  16  saturating count of locked-state word errors.
- word_count  output  32  valid words received while locked (see Configuration).

## Operation
- Next-state function: next(s) = {s[N-2:0], ^(s & TAPS)}.
- Internal registers: state, exp (expected next word, N bits), run (8-bit match/mismatch run counter).
- Nothing happens on cycles with in_valid=0; all state holds.
- The FSM has three states.
- **HUNT** (reset state):
  - Valid nonzero word: exp <= next(in_data), run <= 0, go to VERIFY.
  - Valid zero word: ignored, because the all-zero word is the LFSR lock-up state. Stay in HUNT.
- **VERIFY**:
  - Match (in_data == exp): exp <= next(exp), run <= run+1. When run+1 == LOCK_COUNT, go to LOCKED and set run <= 0.
  - Mismatch with nonzero in_data: reseed with exp <= next(in_data), run <= 0, stay in VERIFY.
  - Mismatch with zero in_data: go to HUNT.
  - No errors are counted in VERIFY.
- **LOCKED**:
  - Every valid word: exp <= next(exp). The checker flywheels and never reseeds while locked.
  - Match: run <= 0.
  - Mismatch: err_pulse asserts, err_count increments (saturating at 16'hFFFF), run <= run+1.
  - When run+1 == LOSS_THRESH, go to HUNT. The error that triggers loss of lock is still counted.
- clr_cnt:
  - Asserted alone: err_count <= 0.
  - Asserted in the same cycle as a counted error: err_count <= 1.
- Reset mid-operation: all state is lost immediately and the next valid word restarts the hunt.

## Timing
- Reset values: state=HUNT, exp=0, run=0, locked=0, err_pulse=0, err_count=0, word_count=0.
- All outputs are registered.
- Latency: a valid word sampled on edge t affects locked, err_pulse and err_count on edge t+1.
- Lock acquisition takes 1 + LOCK_COUNT valid words. locked rises one cycle after the last matching word.
- Loss of lock: locked falls one cycle after the LOSS_THRESH-th consecutive mismatch. err_pulse is high in that same cycle.
- Back-to-back valid words every cycle are supported. There is no backpressure and no ready signal.

## Configuration
- Macro: LFSR_CHK_WORDCNT_EN.
- Defined: word_count increments on every valid word accepted while locked (before the state update). It wraps at 2^32, and clr_cnt clears it together with err_count.
- Undefined: the counter logic is not built and word_count is tied to 0. The port is always present.

## Test plan
- Lock acquisition (LOCK_COUNT=4): feed 0x01, 0x02, 0x04, 0x08, 0x11 on consecutive cycles -> locked=1 one cycle after 0x11, err_count=0.
- Locked error: after lock, feed 0x23, 0xFF (expected 0x47), 0x8E -> exactly one err_pulse, err_count=1, locked stays 1, and 0x8E is accepted as a match (flywheel).
- Loss of lock (LOSS_THRESH=4): after lock, feed four words of 0x00 -> err_count=4, locked=0 after the fourth. Then feed 0x00 followed by 0x01 through 0x11 -> hunt ignores 0x00, and lock is reacquired after 0x11.
- VERIFY reseed: feed 0x01, 0x02, 0x55, next(0x55), and three further next() words -> no lock on the 0x01 seed, lock after the fourth match following 0x55, err_count=0.
- Saturation and clear: force 0x10000 or more locked errors -> err_count holds at 0xFFFF. Assert clr_cnt in the same cycle as an error -> err_count=1.
- Async reset mid-lock: assert rst between clock edges -> locked, err_count and word_count go to 0 immediately, without waiting for a clock edge. With LFSR_CHK_WORDCNT_EN, 10 locked valid words give word_count=10.
